// File: rtl/dac_arbiter.sv
// dac_arbiter: round-robin share of one SPI DAC link between channels A and B, with CS-gap and LDAC control.
// Ports:
//   clk                    system clock
//   rst                    asynchronous reset, active low
//   a_data/a_valid/a_ready channel A sample request (ready is combinational)
//   b_data/b_valid/b_ready channel B sample request (ready is combinational)
//   spi_start/spi_data     one-cycle start strobe and 16-bit command word to the SPI engine
//   spi_cs                 chip-select from the SPI engine, low while a frame is in progress
//   ldac_n                 DAC load strobe, active low
//   busy                   high in every state except IDLE
//   fault                  one-cycle pulse when spi_cs fails to fall after a start
module dac_arbiter #(
    parameter int GAP_CYCLES  = 4,
    parameter int LDAC_CYCLES = 2,
    parameter bit SYNC_LDAC   = 1'b1,
    parameter int CS_TIMEOUT  = 8,
    parameter bit GAIN_1X     = 1'b1,
    parameter bit BUF_EN      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] a_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [11:0] b_data,
    input  logic        b_valid,
    output logic        b_ready,
    output logic        spi_start,
    output logic [15:0] spi_data,
    input  logic        spi_cs,
    output logic        ldac_n,
    output logic        busy,
    output logic        fault
);
    localparam int TMAX = (GAP_CYCLES > LDAC_CYCLES) ?
                          ((GAP_CYCLES > CS_TIMEOUT) ? GAP_CYCLES : CS_TIMEOUT) :
                          ((LDAC_CYCLES > CS_TIMEOUT) ? LDAC_CYCLES : CS_TIMEOUT);
    localparam int TW = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, GAP, LDAC} state_t;

    state_t        state;
    logic          last_b;
    logic [TW-1:0] timer;
    logic          ldac_due;

    // last_b also records which channel the current frame belongs to
    assign ldac_due = !SYNC_LDAC || last_b;
    assign a_ready  = (state == IDLE) && a_valid && (!b_valid || last_b);
    assign b_ready  = (state == IDLE) && b_valid && (!a_valid || !last_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            timer     <= '0;
            spi_start <= 1'b0;
            spi_data  <= '0;
            ldac_n    <= 1'b1;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            fault     <= 1'b0;
            case (state)
                IDLE: if (a_ready || b_ready) begin
                    spi_data  <= {b_ready, BUF_EN, GAIN_1X, 1'b1, b_ready ? b_data : a_data};
                    last_b    <= b_ready;
                    spi_start <= 1'b1;
                    busy      <= 1'b1;
                    state     <= START;
                end
                START: begin
                    timer <= '0;
                    state <= WAIT_LOW;
                end
                WAIT_LOW:
                    if (!spi_cs) state <= WAIT_HIGH;
                    else if (timer == TW'(CS_TIMEOUT - 1)) begin
                        fault <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else timer <= timer + 1'b1;
                WAIT_HIGH: if (spi_cs) begin
                    timer <= '0;
                    state <= GAP;
                end
                GAP:
                    if (timer == TW'(GAP_CYCLES - 1)) begin
                        timer  <= '0;
                        ldac_n <= !ldac_due;
                        busy   <= ldac_due;
                        state  <= ldac_due ? LDAC : IDLE;
                    end else timer <= timer + 1'b1;
                LDAC:
                    if (timer == TW'(LDAC_CYCLES - 1)) begin
                        ldac_n <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else timer <= timer + 1'b1;
                default: begin
                    ldac_n <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_arbiter.sv
// tb_dac_arbiter: scoreboard bench for dac_arbiter with a behavioural SPI engine model.
module tb_dac_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst0 = 1'b0;
    logic [11:0] a_data = '0, b_data = '0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        spi_cs = 1'b1;
    logic        a_ready, b_ready, spi_start, ldac_n, busy, fault;
    logic [15:0] spi_data;
    logic        a_ready0, b_ready0, spi_start0, ldac_n0, busy0, fault0;
    logic [15:0] spi_data0;

    int checks = 0, passed = 0, cyc = 0;
    int starts = 0, start_cyc = 0, faults = 0, fault_cyc = 0;
    int cs_rise_cyc = 0, busy_fall_cyc = 0, ldac_pulses = 0, a_ready_cnt = 0;
    int starts0 = 0, s0_prev = 0, s0_last = 0, ldac0_low = 0;
    int hold = 5;
    bit spi_never = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_arbiter dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .spi_start(spi_start), .spi_data(spi_data), .spi_cs(spi_cs),
        .ldac_n(ldac_n), .busy(busy), .fault(fault)
    );

    // Second instance for the every-frame LDAC mode; held in reset outside its phase
    dac_arbiter #(.SYNC_LDAC(1'b0)) dut0 (
        .clk(clk), .rst(rst0),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready0),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready0),
        .spi_start(spi_start0), .spi_data(spi_data0), .spi_cs(spi_cs),
        .ldac_n(ldac_n0), .busy(busy0), .fault(fault0)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // SPI engine: pulls cs low one cycle after a start, holds it for 'hold' cycles
    initial forever begin
        @(negedge clk);
        if ((spi_start || spi_start0) && !spi_never) begin
            tick;
            spi_cs = 1'b0;
            repeat (hold) tick;
            spi_cs = 1'b1;
        end
    end

    // Scoreboard monitor and event recorders for the main instance
    initial begin
        bit prev_xfer = 1'b0, prev_busy = 1'b0, prev_cs = 1'b1;
        int low_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (spi_start) begin
                    starts++;
                    start_cyc = cyc;
                    if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
                    else chk("spi_data", int'(spi_data), int'(exp_q.pop_front()));
                end
                if (prev_xfer || spi_start) chk("start_latency", int'(spi_start), int'(prev_xfer));
                if (fault) begin
                    faults++;
                    fault_cyc = cyc;
                end
                if (a_ready) a_ready_cnt++;
                if (prev_busy && !busy) busy_fall_cyc = cyc;
                if (!prev_cs && spi_cs) cs_rise_cyc = cyc;
                if (!ldac_n) low_cnt++;
                else if (low_cnt != 0) begin
                    chk("ldac_width", low_cnt, 2);
                    ldac_pulses++;
                    low_cnt = 0;
                end
            end else low_cnt = 0;
            prev_xfer = rst && ((a_valid && a_ready) || (b_valid && b_ready));
            prev_busy = busy;
            prev_cs = spi_cs;
        end
    end

    always @(negedge clk) if (rst0) begin
        if (spi_start0) begin
            s0_prev = s0_last;
            s0_last = cyc;
            starts0++;
        end
        if (!ldac_n0) ldac0_low++;
    end

    task automatic wait_starts(input int n);
        int k = 0;
        while (starts < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (starts < n) chk("start_wait_timeout", starts, n);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk(name, 1, 0);
        tick;
    endtask

    task automatic req_a(input logic [11:0] d);
        tick;
        a_valid = 1'b1;
        a_data = d;
        tick;
        a_valid = 1'b0;
    endtask

    task automatic req_b(input logic [11:0] d);
        tick;
        b_valid = 1'b1;
        b_data = d;
        tick;
        b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        repeat (2) tick;
        chk("rst_spi_start", int'(spi_start), 0);
        chk("rst_spi_data", int'(spi_data), 0);
        chk("rst_ldac_n", int'(ldac_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_a_ready", int'(a_ready), 0);
        chk("rst_b_ready", int'(b_ready), 0);
        rst = 1'b1;

        // Single A request
        exp_q.push_back(16'h35A3);
        tick;
        a_valid = 1'b1;
        a_data = 12'h5A3;
        #1;
        chk("single_a_ready", int'(a_ready), 1);
        chk("single_b_ready", int'(b_ready), 0);
        tick;
        a_valid = 1'b0;
        wait_starts(1);
        wait_idle("single_idle_timeout");
        // cs driven just after an edge is first seen by the DUT on the following edge
        chk("gap_to_idle", busy_fall_cyc - cs_rise_cyc, 4 + 1);
        chk("single_no_ldac", ldac_pulses, 0);

        // CS timeout, then a normal frame
        spi_never = 1'b1;
        exp_q.push_back(16'h30F0);
        req_a(12'h0F0);
        wait_starts(2);
        wait_idle("timeout_idle_timeout");
        chk("fault_count", faults, 1);
        chk("fault_timing", fault_cyc - start_cyc, 8 + 1);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_no_ldac", ldac_pulses, 0);
        spi_never = 1'b0;
        exp_q.push_back(16'h3001);
        req_a(12'h001);
        wait_starts(3);
        wait_idle("after_timeout_idle_timeout");
        chk("fault_count_after", faults, 1);

        // Withdrawn A request during a B frame
        exp_q.push_back(16'hB222);
        req_b(12'h222);
        wait_starts(4);
        base = a_ready_cnt;
        a_valid = 1'b1;
        a_data = 12'h777;
        repeat (3) tick;
        a_valid = 1'b0;
        wait_idle("withdraw_idle_timeout");
        repeat (10) tick;
        chk("withdraw_no_ready", a_ready_cnt - base, 0);
        chk("withdraw_no_frame", starts, 4);
        chk("b_frame_ldac", ldac_pulses, 1);

        // Throughput with every-frame LDAC on the second instance
        rst = 1'b0;
        rst0 = 1'b1;
        hold = 40;
        a_valid = 1'b1;
        a_data = 12'h077;
        k = 0;
        while (starts0 < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("tp_starts", starts0, 2);
        tick;
        a_valid = 1'b0;
        k = 0;
        while (busy0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        tick;
        // START + WAIT_LOW + 40 cs-low + GAP + LDAC + one IDLE cycle
        chk("tp_start_spacing", s0_last - s0_prev, 1 + 1 + 40 + 4 + 2 + 1);
        chk("tp_spacing_min", int'((s0_last - s0_prev) >= 40 + 4 + 2), 1);
        chk("tp_spi_data", int'(spi_data0), 16'h3077);
        chk("tp_ldac_low_cycles", ldac0_low, 4);
        rst0 = 1'b0;
        hold = 5;
        tick;
        rst = 1'b1;

        // Reset during WAIT_HIGH
        exp_q.push_back(16'hB222);
        req_b(12'h222);
        wait_starts(5);
        repeat (3) tick;
        rst = 1'b0;
        #1;
        chk("rst_wh_spi_start", int'(spi_start), 0);
        chk("rst_wh_ldac_n", int'(ldac_n), 1);
        chk("rst_wh_busy", int'(busy), 0);
        repeat (2) tick;
        rst = 1'b1;
        k = 0;
        while (!spi_cs && k < 50) begin
            tick;
            k++;
        end
        repeat (2) tick;

        // Reset during LDAC
        exp_q.push_back(16'hB222);
        req_b(12'h222);
        wait_starts(6);
        k = 0;
        while (ldac_n && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ldac_reached", int'(ldac_n), 0);
        tick;
        rst = 1'b0;
        #1;
        chk("rst_ldac_ldac_n", int'(ldac_n), 1);
        chk("rst_ldac_busy", int'(busy), 0);
        chk("rst_ldac_spi_start", int'(spi_start), 0);
        repeat (2) tick;
        rst = 1'b1;
        tick;

        // Contention: A wins first after reset, then alternation
        exp_q.push_back(16'h3111);
        exp_q.push_back(16'hB222);
        exp_q.push_back(16'h3111);
        exp_q.push_back(16'hB222);
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data = 12'h111;
        b_data = 12'h222;
        #1;
        chk("cont_a_ready", int'(a_ready), 1);
        chk("cont_b_ready", int'(b_ready), 0);
        wait_starts(10);
        tick;
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_idle("cont_idle_timeout");
        chk("cont_ldac_pulses", ldac_pulses, 1 + 2);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
